// File: rtl/column_reduce.sv
`default_nettype none
// column_reduce: sums every column of each beat, then accumulates the beat sums over a frame.
// Build option COLUMN_REDUCE_SAT_EN clips each frame result to the signed DATA_W range.  Revision 1.0
module column_reduce #(
    parameter int DATA_W   = 32,
    parameter int NUM_COLS = 8,
    parameter int BEATS    = 8,
    parameter int ACC_W    = DATA_W + $clog2(NUM_COLS) + $clog2(BEATS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       startAdd,
    input  logic                       inValid,
    input  logic [NUM_COLS*DATA_W-1:0] colData,
    output logic [ACC_W-1:0]           colAddResult,
    output logic                       colAddResult_Valid,
    output logic                       busy,
    output logic                       frameAbort,
    output logic                       satFlag
);
    localparam int               CNT_W     = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;

    logic             accept;
    logic             beat_last;
    logic [ACC_W-1:0] beat_sum;

    logic             s1_valid;
    logic             s1_first;
    logic             s1_last;
    logic [ACC_W-1:0] s1_sum;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] result_next;
    logic             clip;

    // A start beat is always index 0, so it can never also close the frame.
    assign accept    = inValid && (startAdd || state == ACCUM);
    assign beat_last = !startAdd && (beat_cnt == LAST_BEAT);

    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < NUM_COLS; k++) begin
            beat_sum = beat_sum + ACC_W'($signed(colData[k*DATA_W +: DATA_W]));
        end
    end

    // beat_cnt holds the index of the next beat expected in the open frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            busy       <= 1'b0;
            frameAbort <= 1'b0;
        end else begin
            frameAbort <= accept && startAdd && (state == ACCUM);
            if (accept) begin
                if (startAdd) begin
                    state    <= ACCUM;
                    beat_cnt <= CNT_W'(1);
                    busy     <= 1'b1;
                end else if (beat_cnt == LAST_BEAT) begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                    busy     <= 1'b0;
                end else begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_first <= startAdd;
                s1_last  <= beat_last;
                s1_sum   <= beat_sum;
            end
        end
    end

    assign acc_next = s1_first ? s1_sum : (acc + s1_sum);

`ifdef COLUMN_REDUCE_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        result_next = acc_next;
        clip        = 1'b0;
        if ($signed(acc_next) > $signed(SAT_MAX)) begin
            result_next = SAT_MAX;
            clip        = 1'b1;
        end else if ($signed(acc_next) < $signed(SAT_MIN)) begin
            result_next = SAT_MIN;
            clip        = 1'b1;
        end
    end
`else
    assign result_next = acc_next;
    assign clip        = 1'b0;
`endif

    // The final frame total is formed and registered on the same edge, giving two-cycle latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc                <= '0;
            colAddResult       <= '0;
            colAddResult_Valid <= 1'b0;
            satFlag            <= 1'b0;
        end else begin
            colAddResult_Valid <= s1_valid && s1_last;
            if (s1_valid) begin
                acc <= acc_next;
            end
            if (s1_valid && s1_last) begin
                colAddResult <= result_next;
                satFlag      <= clip;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_column_reduce.sv
`default_nettype none
// tb_column_reduce: randomized and directed frames checked against a frame-level sum model.
module tb_column_reduce;
    localparam int DATA_W   = 32;
    localparam int NUM_COLS = 8;
    localparam int BEATS    = 8;
    localparam int ACC_W    = DATA_W + $clog2(NUM_COLS) + $clog2(BEATS);
    localparam int BUS_W    = NUM_COLS * DATA_W;
    localparam longint MAXV = (longint'(1) <<< (DATA_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DATA_W - 1));

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             startAdd = 1'b0;
    logic             inValid = 1'b0;
    logic [BUS_W-1:0] colData = '0;
    logic [ACC_W-1:0] colAddResult;
    logic             colAddResult_Valid;
    logic             busy;
    logic             frameAbort;
    logic             satFlag;

    column_reduce #(
        .DATA_W  (DATA_W),
        .NUM_COLS(NUM_COLS),
        .BEATS   (BEATS),
        .ACC_W   (ACC_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .startAdd          (startAdd),
        .inValid           (inValid),
        .colData           (colData),
        .colAddResult      (colAddResult),
        .colAddResult_Valid(colAddResult_Valid),
        .busy              (busy),
        .frameAbort        (frameAbort),
        .satFlag           (satFlag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               t;
        logic [ACC_W-1:0] v;
        logic             s;
    } res_t;

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    res_t   obs_q[$];
    res_t   exp_q[$];
    int     abort_obs[$];
    int     abort_exp[$];
    res_t   mon_r;

    // Frame model: which beats belong to the open frame and their running total.
    bit     m_busy = 0;
    int     m_cnt = 0;
    longint m_sum = 0;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (colAddResult_Valid === 1'b1) begin
                mon_r.t = cyc;
                mon_r.v = colAddResult;
                mon_r.s = satFlag;
                obs_q.push_back(mon_r);
            end
            if (frameAbort === 1'b1) abort_obs.push_back(cyc);
        end
    end

    function automatic logic [BUS_W-1:0] mk(input int base, input int stp);
        logic [BUS_W-1:0] d;
        for (int k = 0; k < NUM_COLS; k++) d[k*DATA_W +: DATA_W] = 32'(base + stp * k);
        return d;
    endfunction

    function automatic logic [BUS_W-1:0] rand_data();
        logic [BUS_W-1:0] d;
        for (int k = 0; k < NUM_COLS; k++) d[k*DATA_W +: DATA_W] = $urandom;
        return d;
    endfunction

    function automatic longint col_total(input logic [BUS_W-1:0] d);
        longint s = 0;
        for (int k = 0; k < NUM_COLS; k++) s += longint'($signed(d[k*DATA_W +: DATA_W]));
        return s;
    endfunction

    function automatic res_t expect_of(input longint s, input int t);
        res_t   r;
        longint w;
        w   = (s <<< (64 - ACC_W)) >>> (64 - ACC_W);
        r.t = t;
        r.s = 1'b0;
`ifdef COLUMN_REDUCE_SAT_EN
        if (w > MAXV) begin
            w   = MAXV;
            r.s = 1'b1;
        end else if (w < MINV) begin
            w   = MINV;
            r.s = 1'b1;
        end
`endif
        r.v = w[ACC_W-1:0];
        return r;
    endfunction

    task automatic sb_clear();
        obs_q.delete();
        exp_q.delete();
        abort_obs.delete();
        abort_exp.delete();
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_cnt  = 0;
        m_sum  = 0;
    endtask

    // One clock period of stimulus; the model sees the same beat the DUT samples.
    task automatic step(input bit st, input bit v, input logic [BUS_W-1:0] d);
        startAdd = st;
        inValid  = v;
        colData  = d;
        @(posedge clk);
        cyc++;
        if (reset && v && (st || m_busy)) begin
            if (st) begin
                if (m_busy) abort_exp.push_back(cyc);
                m_cnt = 0;
                m_sum = 0;
            end
            m_sum += col_total(d);
            m_cnt++;
            if (m_cnt == BEATS) begin
                exp_q.push_back(expect_of(m_sum, cyc + 1));
                m_busy = 0;
                m_cnt  = 0;
            end else begin
                m_busy = 1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        checks++;
        if (colAddResult !== '0 || colAddResult_Valid !== 1'b0 || busy !== 1'b0 ||
            frameAbort !== 1'b0 || satFlag !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got res=%0d vld=%b busy=%b abort=%b sat=%b, expected all 0",
                     colAddResult, colAddResult_Valid, busy, frameAbort, satFlag);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, mk(1, 1));
            checks++;
            if (colAddResult_Valid !== 1'b0 || busy !== 1'b0 || frameAbort !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: got vld=%b busy=%b abort=%b, expected 0 0 0",
                         colAddResult_Valid, busy, frameAbort);
            end
        end
        reset = 1'b1;
        model_reset();
        idle(2);
        checks++;
        if (busy !== 1'b0 || colAddResult !== '0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b res=%0d, expected 0 0", busy, colAddResult);
        end
    endtask

    task automatic test_alternating();
        logic [ACC_W-1:0] zero = '0;
        sb_clear();
        for (int b = 0; b < BEATS; b++) step(b == 0, 1'b1, (b % 2 == 0) ? mk(1, 1) : mk(-1, -1));
        idle(4);
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL alt_count: got %0d valids, expected %0d", obs_q.size(), exp_q.size());
        end else begin
            checks++;
            if (obs_q[0].t !== exp_q[0].t || obs_q[0].v !== zero) begin
                errors++;
                $display("FAIL alt_result: got t=%0d v=%0d, expected t=%0d v=0",
                         obs_q[0].t, $signed(obs_q[0].v), exp_q[0].t);
            end
        end
    endtask

    task automatic test_gaps();
        logic [ACC_W-1:0] e288 = ACC_W'(288);
        sb_clear();
        for (int b = 0; b < BEATS; b++) begin
            step(b == 0, 1'b1, mk(1, 1));
            checks++;
            if (busy !== m_busy) begin
                errors++;
                $display("FAIL gaps_busy[%0d]: got %b, expected %b", b, busy, m_busy);
            end
            if (b == 2 || b == 5) begin
                step(1'b0, 1'b0, mk(9, 9));
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL gaps_busy_gap[%0d]: got %b, expected 1", b, busy);
                end
            end
        end
        idle(4);
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL gaps_count: got %0d valids, expected %0d", obs_q.size(), exp_q.size());
        end else begin
            checks++;
            if (obs_q[0].t !== exp_q[0].t || obs_q[0].v !== e288) begin
                errors++;
                $display("FAIL gaps_result: got t=%0d v=%0d, expected t=%0d v=288",
                         obs_q[0].t, $signed(obs_q[0].v), exp_q[0].t);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [ACC_W-1:0] ep = ACC_W'(288);
        logic [ACC_W-1:0] en = -ACC_W'(288);
        sb_clear();
        for (int b = 0; b < BEATS; b++) step(b == 0, 1'b1, mk(1, 1));
        for (int b = 0; b < BEATS; b++) step(b == 0, 1'b1, mk(-1, -1));
        idle(4);
        checks++;
        if (obs_q.size() != 2 || exp_q.size() != 2 || abort_obs.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d valids %0d aborts, expected 2 valids 0 aborts",
                     obs_q.size(), abort_obs.size());
        end else begin
            checks++;
            if (obs_q[0].v !== ep || obs_q[1].v !== en || obs_q[1].t - obs_q[0].t != BEATS ||
                obs_q[0].t !== exp_q[0].t) begin
                errors++;
                $display("FAIL b2b_result: got %0d@%0d %0d@%0d, expected 288@%0d -288@%0d",
                         $signed(obs_q[0].v), obs_q[0].t, $signed(obs_q[1].v), obs_q[1].t,
                         exp_q[0].t, exp_q[1].t);
            end
        end
    endtask

    task automatic test_restart();
        logic [ACC_W-1:0] e128 = ACC_W'(128);
        sb_clear();
        for (int b = 0; b < 3; b++) step(b == 0, 1'b1, mk(1, 1));
        for (int b = 0; b < BEATS; b++) step(b == 0, 1'b1, mk(2, 0));
        idle(4);
        checks++;
        if (abort_obs.size() != 1 || abort_exp.size() != 1 || abort_obs[0] != abort_exp[0]) begin
            errors++;
            $display("FAIL restart_abort: got %0d pulses, expected 1 at cycle %0d",
                     abort_obs.size(), (abort_exp.size() > 0) ? abort_exp[0] : -1);
        end
        checks++;
        if (obs_q.size() != 1 || obs_q[0].v !== e128 || obs_q[0].t !== exp_q[0].t) begin
            errors++;
            $display("FAIL restart_result: got %0d valids, first v=%0d, expected 1 valid of 128",
                     obs_q.size(), (obs_q.size() > 0) ? $signed(obs_q[0].v) : 0);
        end
    endtask

    task automatic test_saturation();
        logic [ACC_W-1:0] ev;
        logic             es;
`ifdef COLUMN_REDUCE_SAT_EN
        ev = ACC_W'(64'd2147483647);
        es = 1'b1;
`else
        ev = ACC_W'(64'd137438953408);
        es = 1'b0;
`endif
        sb_clear();
        for (int b = 0; b < BEATS; b++) step(b == 0, 1'b1, mk(32'h7fffffff, 0));
        idle(4);
        checks++;
        if (obs_q.size() != 1 || obs_q[0].v !== ev || obs_q[0].s !== es || obs_q[0].t !== exp_q[0].t) begin
            errors++;
            $display("FAIL sat_result: got %0d valids, v=%0d sat=%b, expected v=%0d sat=%b",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0].v : '0,
                     (obs_q.size() > 0) ? obs_q[0].s : 1'bx, ev, es);
        end
    endtask

    task automatic test_reset_midframe();
        logic [ACC_W-1:0] e288 = ACC_W'(288);
        sb_clear();
        for (int b = 0; b < 4; b++) step(b == 0, 1'b1, mk(1, 1));
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || colAddResult !== '0) begin
            errors++;
            $display("FAIL midreset_clear: got busy=%b res=%0d, expected 0 0", busy, colAddResult);
        end
        idle(2);
        reset = 1'b1;
        model_reset();
        idle(2);
        for (int b = 0; b < BEATS; b++) step(b == 0, 1'b1, mk(1, 1));
        idle(4);
        checks++;
        if (obs_q.size() != 1 || obs_q[0].v !== e288 || obs_q[0].t !== exp_q[0].t) begin
            errors++;
            $display("FAIL midreset_result: got %0d valids, first v=%0d, expected 1 valid of 288",
                     obs_q.size(), (obs_q.size() > 0) ? $signed(obs_q[0].v) : 0);
        end
    endtask

    task automatic test_random();
        int r;
        sb_clear();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (!m_busy) begin
                if (r < 40)      step(1'b1, 1'b1, rand_data());
                else if (r < 55) step(1'b1, 1'b0, rand_data());
                else if (r < 70) step(1'b0, 1'b1, rand_data());
                else             step(1'b0, 1'b0, rand_data());
            end else begin
                if (r < 75)      step(1'b0, 1'b1, rand_data());
                else if (r < 80) step(1'b1, 1'b1, rand_data());
                else             step(1'b0, 1'b0, rand_data());
            end
        end
        idle(4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d valids, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].t !== exp_q[i].t || obs_q[i].v !== exp_q[i].v || obs_q[i].s !== exp_q[i].s) begin
                errors++;
                $display("FAIL rand_result[%0d]: got t=%0d v=%0d sat=%b, expected t=%0d v=%0d sat=%b",
                         i, obs_q[i].t, $signed(obs_q[i].v), obs_q[i].s,
                         exp_q[i].t, $signed(exp_q[i].v), exp_q[i].s);
            end
        end
        checks++;
        if (abort_obs != abort_exp) begin
            errors++;
            $display("FAIL rand_abort: got %0d pulses, expected %0d", abort_obs.size(), abort_exp.size());
        end
    endtask

    initial begin
        test_reset();
        test_alternating();
        test_gaps();
        test_back_to_back();
        test_restart();
        test_saturation();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/column_reduce.md
COLUMN_REDUCE -- requirements
Module: column_reduce

Interface
REQ-001 SHALL have parameter DATA_W, default 32, signed width of each column element.
REQ-002 SHALL have parameter NUM_COLS, default 8, columns per beat (power of two, 2..32).
REQ-003 SHALL have parameter BEATS, default 8, beats per frame (2..256).
REQ-004 SHALL have parameter ACC_W, default DATA_W+clog2(NUM_COLS)+clog2(BEATS), accumulator and result width.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 SHALL have port startAdd  input  1  marks the first beat of a frame.
REQ-008 SHALL have port inValid  input  1  colData carries a beat this cycle.
REQ-009 SHALL have port colData  input  NUM_COLS*DATA_W  packed signed columns; column k at bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port colAddResult  output  ACC_W  signed frame sum.
REQ-011 SHALL have port colAddResult_Valid  output  1  one-cycle pulse when colAddResult is new.
REQ-012 SHALL have port busy  output  1  high while a frame has accepted at least one beat and fewer than BEATS beats.
REQ-013 SHALL have port frameAbort  output  1  one-cycle pulse when a partial frame is discarded.
REQ-014 SHALL have port satFlag  output  1  result was clipped (see Configuration).

Function
REQ-015 Beat acceptance SHALL be: inValid=1 and (startAdd=1 or busy=1); all other cycles ignored, including startAdd=1 with inValid=0.
REQ-016 A beat with startAdd=1 SHALL be beat 0 of a new frame; beat counter counts accepted beats 0..BEATS-1 and wraps to idle after BEATS-1.
REQ-017 Stage 1 SHALL register the sign-extended ACC_W sum of all NUM_COLS columns of each accepted beat, tagged first/last.
REQ-018 Stage 2 SHALL load the stage-1 sum on a first-tagged beat and add it otherwise; wrap-around two's complement in ACC_W.
REQ-019 Latency: last beat accepted at cycle T SHALL give colAddResult_Valid=1 at T+2 only; colAddResult holds its value until the next valid.
REQ-020 inValid=0 gaps inside a frame SHALL stall counting without changing the sum.
REQ-021 startAdd with inValid=1 on the cycle after a last beat SHALL start a new frame with no bubble; both results SHALL be correct.
REQ-022 startAdd with inValid=1 while busy=1 SHALL discard the partial frame, pulse frameAbort at the same cycle+1, and treat the beat as beat 0; the discarded frame produces no valid.
REQ-023 States: IDLE (busy=0), ACCUM (busy=1); IDLE->ACCUM on start beat, ACCUM->IDLE on beat BEATS-1, ACCUM->ACCUM on restart.

Reset
REQ-024 reset=0 SHALL asynchronously clear counter, pipeline tags, accumulator, colAddResult=0, colAddResult_Valid=0, busy=0, frameAbort=0, satFlag=0.
REQ-025 Reset mid-frame SHALL discard the frame with no valid pulse; first start after release begins cleanly.

Configuration
REQ-026 With macro COLUMN_REDUCE_SAT_EN defined, colAddResult SHALL be the ACC_W sum clipped to signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1], sign-extended to ACC_W, with satFlag=1 alongside the valid pulse when clipping occurred; same latency.
REQ-027 Without COLUMN_REDUCE_SAT_EN, colAddResult SHALL be the unclipped ACC_W sum and satFlag SHALL be constant 0.

Verification (defaults)
REQ-028 Start + 8 consecutive beats alternating {1..8} and {-1..-8} -> colAddResult=0, valid exactly 2 cycles after beat 8.
REQ-029 8 beats of {1..8} with inValid=0 gaps after beats 2 and 5 -> colAddResult=288, valid 2 cycles after last beat, busy high from beat 0 through beat 7.
REQ-030 Two frames back-to-back ({1..8} x8, then {-1..-8} x8) -> valid pulses 8 cycles apart with 288 then -288.
REQ-031 Start, 3 beats of {1..8}, restart with 8 beats of {2,2,..} -> frameAbort one pulse, single result 128.
REQ-032 8 beats all columns 0x7FFFFFFF -> without macro 137438953408, satFlag=0; with macro 2147483647, satFlag=1.
REQ-033 reset=0 after beat 4 then frame of {1..8} x8 -> no valid during first frame, second result 288.
